multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Moore-style control FSM that sequences the shared multicycle MIPS-subset datapath: one ALU, one memory port and one register file, reused across the instruction steps. It runs the fetch/decode/execute/memory/writeback sequence for R-, I- and J-type instructions. Fetch and data accesses wait on a memory-ready handshake, protected by a watchdog. The block counts retired instructions and traps on illegal encodings or memory timeouts. It sits in CPU_TOP beside the datapath and drives all datapath mux and enable controls.

Parameters:
RET_W, 32, width of retired-instruction counter
TIMEOUT, 16, maximum cycles spent waiting on mem_ready before trap (range 1..255)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
opcode  input  6  IR[31:26]
funct  input  6  IR[5:0]
zero  input  1  ALU zero flag
mem_ready  input  1  memory access completes this cycle
pc_write  output  1  PC load enable
ir_write  output  1  IR load enable
iord  output  1  memory address select: 0=PC, 1=ALUOut
mem_read  output  1  memory read request
mem_write  output  1  memory write request
reg_write  output  1  register-file write enable
reg_dst  output  2  destination register: 00=rt, 01=rd, 10=r31
wb_sel  output  2  write-back data: 00=ALUOut, 01=MDR, 10=PC
alu_src_a  output  1  ALU A input: 0=PC, 1=regA
alu_src_b  output  2  ALU B input: 00=regB, 01=4, 10=ext(imm), 11=sext(imm)<<2
ext_sel  output  1  immediate extension: 0=sign, 1=zero
alu_op  output  4  ALU operation: 0=ADD, 1=SUB, 2=AND, 3=OR, 4=SLT
pc_source  output  2  PC source: 00=ALU result, 01=ALUOut, 10=jump target
state  output  4  current state, for debug
trap  output  1  sticky trap flag
trap_cause  output  2  01=illegal encoding, 10=memory timeout
retired  output  RET_W  retired-instruction count

Behaviour:
- Reset (async, rst_n=0): state=RESET(0), every control output 0, trap=0, trap_cause=0, retired=0, watchdog=0. After rst_n rises, RESET lasts exactly one cycle, then FETCH.
- State codes: RESET 0, FETCH 1, DECODE 2, MEM_ADDR 3, MEM_RD 4, MEM_WB 5, MEM_WR 6, R_EXEC 7, R_WB 8, I_EXEC 9, I_WB 10, BRANCH 11, JUMP 12, TRAP 13.
- Outputs are decoded from the state register plus the latched op_q/fn_q. Only the asserted controls are listed per state; every other control is 0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00. ir_write=1 and pc_write=1 only in the cycle with mem_ready=1, which also moves the FSM to DECODE. Otherwise the FSM stays in FETCH.
- DECODE: latch opcode/funct into op_q/fn_q. Drive alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target into ALUOut).
  - Dispatch: 000000 → R_EXEC; 100011/101011 (lw/sw) → MEM_ADDR; 001000/001100/001101 (addi/andi/ori) → I_EXEC; 000100/000101 (beq/bne) → BRANCH; 000010/000011 (j/jal) → JUMP; any other opcode → TRAP with cause 01.
- R_EXEC: alu_src_a=1, alu_src_b=00. funct 100000/100010/100100/100101/101010 selects ADD/SUB/AND/OR/SLT, then R_WB. Any other funct → TRAP with cause 01, and no writeback occurs.
- R_WB: reg_write=1, reg_dst=01, wb_sel=00 → FETCH.
- I_EXEC: alu_src_a=1, alu_src_b=10. addi: ext_sel=0, ADD. andi: ext_sel=1, AND. ori: ext_sel=1, OR. Next state I_WB.
- I_WB: reg_write=1, reg_dst=00, wb_sel=00 → FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_sel=0, ADD. lw → MEM_RD, sw → MEM_WR.
- MEM_RD: mem_read=1, iord=1. Waits for mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, reg_dst=00, wb_sel=01 → FETCH.
- MEM_WR: mem_write=1, iord=1. Waits for mem_ready, then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_source=01. pc_write=zero for beq, pc_write=~zero for bne. Next state FETCH.
- JUMP: pc_write=1, pc_source=10. jal additionally asserts reg_write=1, reg_dst=10, wb_sel=10; PC already holds PC+4. Next state FETCH.
- Watchdog: counts cycles spent in FETCH/MEM_RD/MEM_WR while mem_ready=0. It clears on mem_ready=1 and on every state change.
  - Reaching TIMEOUT consecutive waiting cycles → TRAP with cause 10. No ir_write, pc_write or reg_write is issued.
  - mem_ready=1 in the same cycle the count would hit TIMEOUT counts as completion, not timeout.
- Retirement: retired increments by 1 on every transition into FETCH from a non-RESET state. It wraps from all-ones to 0.
- TRAP: all controls 0, trap=1, trap_cause held. The FSM stays in TRAP until reset; retired is frozen.
- Reset mid-operation: immediate return to RESET regardless of state or an outstanding memory access; mem_read and mem_write drop asynchronously.

Test Plan:
- add $3,$1,$2 (IR=0x00221820), mem_ready=1 → states 1,2,7,8,1. alu_op=0 in R_EXEC. reg_write=1 with reg_dst=01 for exactly one cycle. retired 0→1.
- lw $4,8($0) with mem_ready low for 3 cycles in MEM_RD → MEM_RD lasts 4 cycles. MEM_WB asserts reg_write=1, wb_sel=01. Total 8 cycles from FETCH to FETCH.
- beq with zero=1, then bne with zero=1 → pc_write=1 in BRANCH for beq, 0 for bne. pc_source=01 both times. Each instruction takes 3 cycles.
- jal (opcode 000011) → JUMP asserts pc_write=1, reg_write=1, reg_dst=10, wb_sel=10 in a single cycle.
- opcode 111111, then after reset funct 000111 → TRAP with cause 01, trap=1, no reg_write. retired unchanged until rst_n is pulsed.
- mem_ready held 0 in FETCH for TIMEOUT=16 cycles → TRAP with cause 10 on the 16th cycle. A second run with mem_ready rising on cycle 16 → DECODE, no trap.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multicycle MIPS-subset datapath: sequences fetch,
// decode, execute, memory and writeback, with a memory watchdog and sticky trap.
module multicycle_ctrl #(
    parameter int RET_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             reg_write,
    output logic [1:0]       reg_dst,
    output logic [1:0]       wb_sel,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             ext_sel,
    output logic [3:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_R_EXEC   = 4'd7,
        S_R_WB     = 4'd8,
        S_I_EXEC   = 4'd9,
        S_I_WB     = 4'd10,
        S_BRANCH   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    // Count value held during the last permitted waiting cycle.
    localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

    function automatic logic funct_legal(input logic [5:0] fn);
        case (fn)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] funct_alu_op(input logic [5:0] fn);
        case (fn)
            FN_ADD:  return ALU_ADD;
            FN_SUB:  return ALU_SUB;
            FN_AND:  return ALU_AND;
            FN_OR:   return ALU_OR;
            FN_SLT:  return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    function automatic state_t dispatch(input logic [5:0] op);
        case (op)
            OP_RTYPE:               return S_R_EXEC;
            OP_LW, OP_SW:           return S_MEM_ADDR;
            OP_ADDI, OP_ANDI, OP_ORI: return S_I_EXEC;
            OP_BEQ, OP_BNE:         return S_BRANCH;
            OP_J, OP_JAL:           return S_JUMP;
            default:                return S_TRAP;
        endcase
    endfunction

    state_t           state_r;
    state_t           state_nx_s;
    logic [5:0]       op_q_r;
    logic [5:0]       fn_q_r;
    logic [7:0]       wd_r;
    logic [7:0]       wd_nx_s;
    logic             wd_hit_s;
    logic [1:0]       cause_nx_s;
    logic             retire_s;
    logic             trap_r;
    logic [1:0]       trap_cause_r;
    logic [RET_W-1:0] retired_r;

    assign wd_hit_s = (wd_r >= WD_LIMIT);

    // Next-state, watchdog and trap-cause selection.
    always_comb begin
        state_nx_s = state_r;
        wd_nx_s    = 8'd0;
        cause_nx_s = CAUSE_NONE;
        case (state_r)
            S_RESET:    state_nx_s = S_FETCH;
            S_FETCH, S_MEM_RD, S_MEM_WR: begin
                if (mem_ready) begin
                    if (state_r == S_FETCH) begin
                        state_nx_s = S_DECODE;
                    end else if (state_r == S_MEM_RD) begin
                        state_nx_s = S_MEM_WB;
                    end else begin
                        state_nx_s = S_FETCH;
                    end
                end else if (wd_hit_s) begin
                    state_nx_s = S_TRAP;
                    cause_nx_s = CAUSE_TIMEOUT;
                end else begin
                    wd_nx_s = wd_r + 8'd1;
                end
            end
            S_DECODE: begin
                state_nx_s = dispatch(opcode);
                cause_nx_s = (dispatch(opcode) == S_TRAP) ? CAUSE_ILLEGAL : CAUSE_NONE;
            end
            S_MEM_ADDR: state_nx_s = (op_q_r == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_R_EXEC: begin
                if (funct_legal(fn_q_r)) begin
                    state_nx_s = S_R_WB;
                end else begin
                    state_nx_s = S_TRAP;
                    cause_nx_s = CAUSE_ILLEGAL;
                end
            end
            S_I_EXEC:   state_nx_s = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: state_nx_s = S_FETCH;
            S_TRAP:     state_nx_s = S_TRAP;
            default: begin
                state_nx_s = S_TRAP;
                cause_nx_s = CAUSE_ILLEGAL;
            end
        endcase
    end

    // A completed instruction is one that re-enters FETCH from anywhere but RESET.
    assign retire_s = (state_nx_s == S_FETCH) && (state_r != S_FETCH) && (state_r != S_RESET);

    // State register, instruction latch, watchdog, trap flags and retire counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= S_RESET;
            op_q_r       <= 6'd0;
            fn_q_r       <= 6'd0;
            wd_r         <= 8'd0;
            trap_r       <= 1'b0;
            trap_cause_r <= CAUSE_NONE;
            retired_r    <= '0;
        end else begin
            state_r <= state_nx_s;
            wd_r    <= wd_nx_s;
            if (state_r == S_DECODE) begin
                op_q_r <= opcode;
                fn_q_r <= funct;
            end else begin
                op_q_r <= op_q_r;
                fn_q_r <= fn_q_r;
            end
            if ((state_nx_s == S_TRAP) && (state_r != S_TRAP)) begin
                trap_r       <= 1'b1;
                trap_cause_r <= cause_nx_s;
            end else begin
                trap_r       <= trap_r;
                trap_cause_r <= trap_cause_r;
            end
            if (retire_s) begin
                retired_r <= retired_r + RET_W'(1);
            end else begin
                retired_r <= retired_r;
            end
        end
    end

    // Datapath controls decoded from the state register and latched opcode/funct.
    always_comb begin
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        iord      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        reg_dst   = 2'b00;
        wb_sel    = 2'b00;
        alu_src_a = 1'b0;
        alu_src_b = 2'b00;
        ext_sel   = 1'b0;
        alu_op    = ALU_ADD;
        pc_source = 2'b00;
        case (state_r)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = 2'b11;
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write = 1'b1;
                wb_sel    = 2'b01;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_R_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = funct_alu_op(fn_q_r);
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 2'b01;
            end
            S_I_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                case (op_q_r)
                    OP_ANDI: begin
                        ext_sel = 1'b1;
                        alu_op  = ALU_AND;
                    end
                    OP_ORI: begin
                        ext_sel = 1'b1;
                        alu_op  = ALU_OR;
                    end
                    default: begin
                        ext_sel = 1'b0;
                        alu_op  = ALU_ADD;
                    end
                endcase
            end
            S_I_WB:     reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                pc_source = 2'b01;
                pc_write  = (op_q_r == OP_BNE) ? ~zero : zero;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
                // PC already holds PC+4 here, so jal links it straight into r31.
                reg_write = (op_q_r == OP_JAL);
                reg_dst   = (op_q_r == OP_JAL) ? 2'b10 : 2'b00;
                wb_sel    = (op_q_r == OP_JAL) ? 2'b10 : 2'b00;
            end
            default: pc_write = 1'b0;
        endcase
    end

    assign state      = state_r;
    assign trap       = trap_r;
    assign trap_cause = trap_cause_r;
    assign retired    = retired_r;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: hand-computed state sequences and
// control values for R/I/memory/branch/jump flows, traps and the watchdog.
module tb_multicycle_ctrl;

    logic        clk;
    logic        rst_n;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        pc_write, ir_write, iord, mem_read, mem_write, reg_write;
    logic [1:0]  reg_dst, wb_sel, alu_src_b, pc_source, trap_cause;
    logic        alu_src_a, ext_sel, trap;
    logic [3:0]  alu_op, state;
    logic [31:0] retired;
    logic [19:0] ctl;

    int vectors;
    int miscompares;

    multicycle_ctrl #(.RET_W(32), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .ir_write(ir_write), .iord(iord),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .reg_dst(reg_dst), .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_sel(ext_sel), .alu_op(alu_op), .pc_source(pc_source), .state(state),
        .trap(trap), .trap_cause(trap_cause), .retired(retired)
    );

    assign ctl = {pc_write, ir_write, iord, mem_read, mem_write, reg_write, reg_dst,
                  wb_sel, alu_src_a, alu_src_b, ext_sel, alu_op, pc_source};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL time_limit: simulation did not finish, observed running, expected done");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rdy, input logic z);
        @(negedge clk);
        mem_ready = rdy;
        zero      = z;
        #1;
    endtask

    task automatic fetch(input logic [5:0] op, input logic [5:0] fn);
        @(negedge clk);
        opcode    = op;
        funct     = fn;
        mem_ready = 1'b1;
        zero      = 1'b0;
        #1;
        check("fetch_state", 32'(state), 32'd1);
        check("fetch_irw", 32'({ir_write, pc_write, mem_read, iord}), 32'b1110);
        check("fetch_alub", 32'(alu_src_b), 32'd1);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_trap", 32'({trap, trap_cause}), 32'd0);
        check("rst_retired", retired, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        opcode      = 6'd0;
        funct       = 6'd0;
        zero        = 1'b0;
        mem_ready   = 1'b0;

        @(negedge clk);
        @(negedge clk);
        check("reset_state", 32'(state), 32'd0);
        check("reset_ctl", 32'(ctl), 32'd0);
        check("reset_trap", 32'({trap, trap_cause}), 32'd0);
        check("reset_retired", retired, 32'd0);
        rst_n = 1'b1;
        #1;
        check("reset_hold", 32'(state), 32'd0);

        // add $3,$1,$2
        fetch(6'b000000, 6'b100000);
        check("add_ret0", retired, 32'd0);
        step(1'b1, 1'b0);
        check("add_decode", 32'(state), 32'd2);
        check("add_dec_alub", 32'(alu_src_b), 32'd3);
        step(1'b1, 1'b0);
        check("add_exec", 32'(state), 32'd7);
        check("add_exec_alu", 32'({alu_src_a, alu_src_b, alu_op}), 32'b1_00_0000);
        check("add_exec_rw", 32'(reg_write), 32'd0);
        step(1'b1, 1'b0);
        check("add_wb", 32'(state), 32'd8);
        check("add_wb_ctl", 32'({reg_write, reg_dst, wb_sel}), 32'b1_01_00);

        // lw $4,8($0) with three not-ready cycles
        fetch(6'b100011, 6'b000000);
        check("add_retired", retired, 32'd1);
        check("add_rw_once", 32'(reg_write), 32'd0);
        step(1'b1, 1'b0);
        check("lw_decode", 32'(state), 32'd2);
        step(1'b1, 1'b0);
        check("lw_addr", 32'(state), 32'd3);
        check("lw_addr_ctl", 32'({alu_src_a, alu_src_b, ext_sel, alu_op}), 32'b1_10_0_0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0);
            check("lw_wait", 32'({state, mem_read, iord}), 32'b0100_1_1);
        end
        step(1'b1, 1'b0);
        check("lw_rd_done", 32'(state), 32'd4);
        step(1'b1, 1'b0);
        check("lw_wb", 32'(state), 32'd5);
        check("lw_wb_ctl", 32'({reg_write, reg_dst, wb_sel}), 32'b1_00_01);

        // beq then bne, both with zero=1
        fetch(6'b000100, 6'b000000);
        check("lw_retired", retired, 32'd2);
        step(1'b1, 1'b0);
        check("beq_decode", 32'(state), 32'd2);
        step(1'b1, 1'b1);
        check("beq_branch", 32'(state), 32'd11);
        check("beq_ctl", 32'({pc_write, pc_source, alu_op}), 32'b1_01_0001);
        fetch(6'b000101, 6'b000000);
        check("beq_retired", retired, 32'd3);
        step(1'b1, 1'b0);
        check("bne_decode", 32'(state), 32'd2);
        step(1'b1, 1'b1);
        check("bne_branch", 32'(state), 32'd11);
        check("bne_ctl", 32'({pc_write, pc_source}), 32'b0_01);

        // sw
        fetch(6'b101011, 6'b000000);
        check("bne_retired", retired, 32'd4);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("sw_addr", 32'(state), 32'd3);
        step(1'b1, 1'b0);
        check("sw_wr", 32'({state, mem_write, iord, mem_read}), 32'b0110_1_1_0);

        // ori
        fetch(6'b001101, 6'b000000);
        check("sw_retired", retired, 32'd5);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("ori_exec", 32'(state), 32'd9);
        check("ori_ctl", 32'({alu_src_a, alu_src_b, ext_sel, alu_op}), 32'b1_10_1_0011);
        step(1'b1, 1'b0);
        check("ori_wb", 32'({state, reg_write, reg_dst, wb_sel}), 32'b1010_1_00_00);

        // jal
        fetch(6'b000011, 6'b000000);
        check("ori_retired", retired, 32'd6);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("jal_state", 32'(state), 32'd12);
        check("jal_ctl", 32'({pc_write, reg_write, reg_dst, wb_sel, pc_source}), 32'b1_1_10_10_10);

        // illegal opcode
        fetch(6'b111111, 6'b000000);
        check("jal_retired", retired, 32'd7);
        step(1'b1, 1'b0);
        check("ill_decode", 32'(state), 32'd2);
        step(1'b1, 1'b0);
        check("ill_trap", 32'({state, trap, trap_cause}), 32'b1101_1_01);
        check("ill_ctl", 32'(ctl), 32'd0);
        step(1'b1, 1'b0);
        check("ill_hold", 32'(state), 32'd13);
        check("ill_frozen", retired, 32'd7);

        // illegal funct
        reset_pulse();
        fetch(6'b000000, 6'b000111);
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        check("fn_exec", 32'({state, reg_write}), 32'b0111_0);
        step(1'b1, 1'b0);
        check("fn_trap", 32'({state, trap, trap_cause}), 32'b1101_1_01);
        check("fn_no_rw", 32'(reg_write), 32'd0);
        check("fn_retired", retired, 32'd0);

        // fetch timeout after 16 not-ready cycles
        reset_pulse();
        for (int k = 1; k <= 16; k++) begin
            step(1'b0, 1'b0);
            check("to_wait", 32'({state, ir_write, pc_write}), 32'b0001_0_0);
        end
        step(1'b0, 1'b0);
        check("to_trap", 32'({state, trap, trap_cause}), 32'b1101_1_10);
        check("to_ctl", 32'(ctl), 32'd0);
        check("to_retired", retired, 32'd0);

        // ready arriving on the 16th cycle completes the fetch
        reset_pulse();
        opcode = 6'b000000;
        funct  = 6'b100000;
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, 1'b0);
            check("late_wait", 32'(state), 32'd1);
        end
        step(1'b1, 1'b0);
        check("late_fetch", 32'({state, ir_write, pc_write}), 32'b0001_1_1);
        step(1'b1, 1'b0);
        check("late_decode", 32'({state, trap}), 32'b0010_0);

        // asynchronous reset drops an outstanding read at once
        reset_pulse();
        step(1'b0, 1'b0);
        check("async_pre", 32'({state, mem_read}), 32'b0001_1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rd", 32'({state, mem_read, mem_write}), 32'b0000_0_0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
